// File: rtl/kvs_pkg.sv
// kvs_pkg: shared KVS widths, flag encodings, request record and a
// saturating-increment helper used by the optional statistics counters.
package kvs_pkg;

  localparam int KEY_SIZE  = 96;
  localparam int VAL_SIZE  = 32;
  localparam int FLAG_SIZE = 4;

  localparam logic [FLAG_SIZE-1:0] FLAG_GET = 4'h1;
  localparam logic [FLAG_SIZE-1:0] FLAG_SET = 4'h2;
  localparam logic [FLAG_SIZE-1:0] FLAG_DEL = 4'h4;
  localparam logic [FLAG_SIZE-1:0] FLAG_HIT = 4'h8;

  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [KEY_SIZE-1:0]  key;
    logic [FLAG_SIZE-1:0] flag;
  } kvs_req_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == STAT_MAX) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/kvs_sync_fifo.sv
// kvs_sync_fifo: single-clock show-ahead FIFO. The head entry is held in a
// registered output (reset to zero) that is loaded either from the memory
// array or, when the write lands on the next head slot, straight from din.
// A push is therefore visible on dout the cycle after it happens.
module kvs_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int LOG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << LOG;
  localparam logic [LOG:0] PTR_ZERO = '0;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LOG:0]     wr_ptr_reg;
  logic [LOG:0]     rd_ptr_reg;
  logic [LOG:0]     rd_ptr_next;
  logic [WIDTH-1:0] dout_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[LOG] != rd_ptr_reg[LOG]) &&
                   (wr_ptr_reg[LOG-1:0] == rd_ptr_reg[LOG-1:0]);
  // Ignore illegal operations so a misbehaving neighbour cannot corrupt pointers.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign rd_ptr_next = rd_ptr_reg + {PTR_ZERO[LOG:1], do_pop};
  assign dout        = dout_reg;

  // Storage array write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[LOG-1:0]] <= din;
    end
  end

  // Read/write pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + {PTR_ZERO[LOG:1], 1'b1};
      end
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Head register: bypass a write that becomes the new head, otherwise fetch
  // the next stored entry after a pop; hold when nothing would change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_reg <= '0;
    end else if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
      dout_reg <= din;
    end else if (do_pop && (rd_ptr_next != wr_ptr_reg)) begin
      dout_reg <= mem[rd_ptr_next[LOG-1:0]];
    end
  end

endmodule

// File: rtl/kvs_req_queue.sv
// kvs_req_queue: buffers parser key requests, issues them to db_top, pairs
// each db_top result pulse with its key and returns key+flag downstream.
// A credit counter (in-flight + buffered responses) caps outstanding work at
// 2**OUT_LOG so db_top result pulses, which cannot be stalled, always fit.
// Optional build macro KVS_QUEUE_STATS_EN adds issue / stall counters.
module kvs_req_queue #(
  parameter int KEY_SIZE  = kvs_pkg::KEY_SIZE,
  parameter int FLAG_SIZE = kvs_pkg::FLAG_SIZE,
  parameter int REQ_LOG   = 4,
  parameter int OUT_LOG   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KEY_SIZE-1:0]  s_key,
  input  logic [FLAG_SIZE-1:0] s_flag,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [KEY_SIZE-1:0]  in_key,
  output logic [FLAG_SIZE-1:0] in_flag,
  output logic                 in_valid,
  input  logic                 in_ready,
  input  logic                 out_valid,
  input  logic [FLAG_SIZE-1:0] out_flag,
  output logic [KEY_SIZE-1:0]  rsp_key,
  output logic [FLAG_SIZE-1:0] rsp_flag,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 busy,
  output logic                 err_spurious,
  output logic [31:0]          stat_req,
  output logic [31:0]          stat_stall
);

  localparam int MAX_OUT = 1 << OUT_LOG;
  localparam logic [OUT_LOG:0] CRED_MAX  = (OUT_LOG+1)'(MAX_OUT);
  localparam logic [OUT_LOG:0] CRED_ZERO = '0;
  localparam logic [OUT_LOG:0] CRED_ONE  = {CRED_ZERO[OUT_LOG:1], 1'b1};
  localparam int REQ_W = KEY_SIZE + FLAG_SIZE;
  localparam int RSP_W = KEY_SIZE + FLAG_SIZE;

  logic                 rdy_reg;
  logic [OUT_LOG:0]     credits_reg;
  logic                 err_reg;

  logic [REQ_W-1:0]     req_dout;
  logic                 req_full;
  logic                 req_empty;
  logic [KEY_SIZE-1:0]  inf_dout;
  logic                 inf_full;
  logic                 inf_empty;
  logic [RSP_W-1:0]     rsp_dout;
  logic                 rsp_full;
  logic                 rsp_empty;

  logic                 req_push;
  logic                 issue;
  logic                 complete;
  logic                 drain;

  assign s_ready  = rdy_reg && !req_full;
  assign req_push = s_valid && s_ready;

  // The credit limit alone keeps the in-flight and response FIFOs from
  // overflowing; their full flags are folded in only as a backstop.
  assign in_valid = !req_empty && (credits_reg != CRED_MAX) && !inf_full && !rsp_full;
  assign issue    = in_valid && in_ready;
  assign {in_key, in_flag} = req_dout;

  assign complete = out_valid && !inf_empty;

  assign rsp_valid = !rsp_empty;
  assign drain     = rsp_valid && rsp_ready;
  assign {rsp_key, rsp_flag} = rsp_dout;

  assign busy         = !req_empty || (credits_reg != CRED_ZERO);
  assign err_spurious = err_reg;

  kvs_sync_fifo #(.WIDTH(REQ_W), .LOG(REQ_LOG)) u_req_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_push),
    .din   ({s_key, s_flag}),
    .pop   (issue),
    .dout  (req_dout),
    .full  (req_full),
    .empty (req_empty)
  );

  kvs_sync_fifo #(.WIDTH(KEY_SIZE), .LOG(OUT_LOG)) u_inflight_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .din   (in_key),
    .pop   (complete),
    .dout  (inf_dout),
    .full  (inf_full),
    .empty (inf_empty)
  );

  kvs_sync_fifo #(.WIDTH(RSP_W), .LOG(OUT_LOG)) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (complete),
    .din   ({inf_dout, out_flag}),
    .pop   (drain),
    .dout  (rsp_dout),
    .full  (rsp_full),
    .empty (rsp_empty)
  );

  // Hold off the parser while reset is active and for the release edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_reg <= 1'b0;
    end else begin
      rdy_reg <= 1'b1;
    end
  end

  // Credits track issued requests whose response has not yet been drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_reg <= '0;
    end else if (issue && !drain) begin
      credits_reg <= credits_reg + CRED_ONE;
    end else if (drain && !issue) begin
      credits_reg <= credits_reg - CRED_ONE;
    end
  end

  // Sticky flag for a db_top result that has no matching request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (out_valid && inf_empty) begin
      err_reg <= 1'b1;
    end
  end

`ifdef KVS_QUEUE_STATS_EN
  logic [31:0] stat_req_reg;
  logic [31:0] stat_stall_reg;

  assign stat_req   = stat_req_reg;
  assign stat_stall = stat_stall_reg;

  // Saturating counts of issued requests and cycles stalled by db_top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_req_reg   <= '0;
      stat_stall_reg <= '0;
    end else begin
      if (issue) begin
        stat_req_reg <= kvs_pkg::sat_inc(stat_req_reg);
      end
      if (in_valid && !in_ready) begin
        stat_stall_reg <= kvs_pkg::sat_inc(stat_stall_reg);
      end
    end
  end
`else
  assign stat_req   = '0;
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_kvs_req_queue.sv
// tb_kvs_req_queue: directed scenarios plus a randomized run, all checked
// against a queue-based reference model of the request/response ordering.
module tb_kvs_req_queue;
  import kvs_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [KEY_SIZE-1:0]  s_key;
  logic [FLAG_SIZE-1:0] s_flag;
  logic                 s_valid;
  logic                 s_ready;
  logic [KEY_SIZE-1:0]  in_key;
  logic [FLAG_SIZE-1:0] in_flag;
  logic                 in_valid;
  logic                 in_ready;
  logic                 out_valid;
  logic [FLAG_SIZE-1:0] out_flag;
  logic [KEY_SIZE-1:0]  rsp_key;
  logic [FLAG_SIZE-1:0] rsp_flag;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 busy;
  logic                 err_spurious;
  logic [31:0]          stat_req;
  logic [31:0]          stat_stall;

  int total = 0;
  int bad   = 0;

  // reference model state
  kvs_req_t m_req[$];
  kvs_req_t m_inf[$];
  kvs_req_t m_rsp[$];
  bit       m_err;
  bit       m_rdy;
  int       m_sreq;
  int       m_sstall;

  always #5 clk = ~clk;

  kvs_req_queue dut (
    .clk          (clk),
    .rst          (rst),
    .s_key        (s_key),
    .s_flag       (s_flag),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .in_key       (in_key),
    .in_flag      (in_flag),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_flag     (out_flag),
    .rsp_key      (rsp_key),
    .rsp_flag     (rsp_flag),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .busy         (busy),
    .err_spurious (err_spurious),
    .stat_req     (stat_req),
    .stat_stall   (stat_stall)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic void model_clear();
    m_req.delete();
    m_inf.delete();
    m_rsp.delete();
    m_err    = 1'b0;
    m_rdy    = 1'b0;
    m_sreq   = 0;
    m_sstall = 0;
  endfunction

  function automatic int m_credits();
    return m_inf.size() + m_rsp.size();
  endfunction

  // Advance one clock: apply the rules of the queue to the model using the
  // inputs currently driven, then move to the next falling edge.
  task automatic tick();
    bit s_fire, can_issue, iss, drn, cmp;
    kvs_req_t e;
    s_fire    = m_rdy && s_valid && (m_req.size() < 16);
    can_issue = (m_req.size() > 0) && (m_credits() < 8);
    iss       = can_issue && in_ready;
    drn       = rsp_ready && (m_rsp.size() > 0);
    cmp       = out_valid && (m_inf.size() > 0);
    if (out_valid && m_inf.size() == 0) m_err = 1'b1;
    if (iss) m_sreq++;
    if (can_issue && !in_ready) m_sstall++;
    if (drn) void'(m_rsp.pop_front());
    if (cmp) begin
      e = m_inf.pop_front();
      e.flag = out_flag;
      m_rsp.push_back(e);
    end
    if (iss) m_inf.push_back(m_req.pop_front());
    if (s_fire) begin
      e.key  = s_key;
      e.flag = s_flag;
      m_req.push_back(e);
    end
    @(posedge clk);
    m_rdy = !rst;
    @(negedge clk);
  endtask

  // Complete and drain everything outstanding, bounded.
  task automatic flush();
    s_valid   = 1'b0;
    in_ready  = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (m_req.size() == 0 && m_inf.size() == 0 && m_rsp.size() == 0) break;
      out_valid = (m_inf.size() > 0);
      out_flag  = FLAG_HIT;
      tick();
    end
    out_valid = 1'b0;
    rsp_ready = 1'b0;
    total++;
    if (m_req.size() + m_inf.size() + m_rsp.size() != 0) begin
      bad++;
      $display("FAIL flush_timeout got=%0d entries left want=0", m_req.size() + m_inf.size() + m_rsp.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 0; s_key = '0; s_flag = '0; in_ready = 0;
    out_valid = 0; out_flag = '0; rsp_ready = 0;
    model_clear();
    repeat (3) @(negedge clk);
    total++; if (s_ready !== 1'b0)   begin bad++; $display("FAIL reset_s_ready got=%b want=0", s_ready); end
    total++; if (in_valid !== 1'b0)  begin bad++; $display("FAIL reset_in_valid got=%b want=0", in_valid); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (err_spurious !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err_spurious); end
    total++; if (in_key !== '0 || rsp_key !== '0) begin bad++; $display("FAIL reset_keys got=%h/%h want=0", in_key, rsp_key); end
    total++; if (stat_req !== 32'd0 || stat_stall !== 32'd0) begin bad++; $display("FAIL reset_stats got=%0d/%0d want=0", stat_req, stat_stall); end
    rst = 1'b0;
    tick();
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL release_s_ready got=%b want=1", s_ready); end
    $display("reset: done");
  endtask

  task automatic test_single();
    s_key = 96'h1; s_flag = FLAG_GET; s_valid = 1; in_ready = 1;
    tick();                       // cycle 0 accept
    s_valid = 0;
    total++; if (in_valid !== 1'b1 || in_key !== 96'h1 || in_flag !== FLAG_GET) begin
      bad++; $display("FAIL single_issue got=%b/%h/%h want=1/1/1", in_valid, in_key, in_flag);
    end
    tick();                       // cycle 1 issue
    total++; if (in_valid !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL single_after_issue got=%b/%b want=0/1", in_valid, busy);
    end
    repeat (3) tick();            // now cycle 5
    out_valid = 1; out_flag = FLAG_HIT;
    tick();
    out_valid = 0;
    total++; if (rsp_valid !== 1'b1 || rsp_key !== 96'h1 || rsp_flag !== FLAG_HIT) begin
      bad++; $display("FAIL single_rsp got=%b/%h/%h want=1/1/8", rsp_valid, rsp_key, rsp_flag);
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    total++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL single_idle got=%b/%b want=0/0", busy, rsp_valid);
    end
    $display("single: rsp key=%h flag=%h", 96'h1, FLAG_HIT);
  endtask

  task automatic test_credit_limit();
    int n = 0;
    in_ready = 1;
    for (int i = 0; i < 12; i++) begin
      s_key = 96'(100 + i); s_flag = FLAG_SET; s_valid = 1;
      if (in_valid) n++;
      tick();
    end
    s_valid = 0;
    for (int i = 0; i < 6; i++) begin
      if (in_valid) n++;
      tick();
    end
    total++; if (n !== 8 || in_valid !== 1'b0) begin
      bad++; $display("FAIL credit_cap got=%0d issued in_valid=%b want=8 issued in_valid=0", n, in_valid);
    end
    out_valid = 1; out_flag = FLAG_HIT;
    tick();
    out_valid = 0;
    total++; if (rsp_valid !== 1'b1 || rsp_key !== 96'd100 || in_valid !== 1'b0) begin
      bad++; $display("FAIL credit_rsp got=%b/%0d/%b want=1/100/0", rsp_valid, rsp_key, in_valid);
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (in_valid) n++;
      tick();
    end
    total++; if (n !== 1) begin bad++; $display("FAIL credit_release got=%0d want=1", n); end
    flush();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL credit_busy got=%b want=0", busy); end
    $display("credit_limit: issued after release=%0d", n);
  endtask

  task automatic test_backpressure();
    in_ready = 0;
    for (int i = 0; i < 17; i++) begin
      s_key = 96'(200 + i); s_flag = FLAG_DEL; s_valid = 1;
      total++; if (s_ready !== (i < 16)) begin
        bad++; $display("FAIL bp_s_ready push=%0d got=%b want=%b", i, s_ready, (i < 16));
      end
      if (i >= 1) begin
        total++; if (in_key !== 96'd200 || in_valid !== 1'b1) begin
          bad++; $display("FAIL bp_hold push=%0d got=%0d want=200", i, in_key);
        end
      end
      tick();
    end
    s_valid = 0;
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%b want=0", s_ready); end
    in_ready = 1;
    for (int i = 0; i < 8; i++) begin
      total++; if (in_valid !== 1'b1 || in_key !== 96'(200 + i)) begin
        bad++; $display("FAIL bp_order idx=%0d got=%0d want=%0d", i, in_key, 200 + i);
      end
      tick();
    end
    flush();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_busy got=%b want=0", busy); end
    $display("backpressure: done");
  endtask

  task automatic test_ordering();
    int exp_k = 1;
    in_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      s_key = 96'(i); s_flag = FLAG_GET; s_valid = 1;
      tick();
    end
    s_valid = 0;
    tick();
    for (int c = 0; c < 40 && exp_k <= 8; c++) begin
      rsp_ready = c[0];
      if (rsp_valid && rsp_ready) begin
        total++; if (rsp_key !== 96'(exp_k) || rsp_flag !== ((exp_k % 2 == 1) ? FLAG_HIT : 4'h0)) begin
          bad++; $display("FAIL order_rsp got=%0d/%h want=%0d/%h", rsp_key, rsp_flag, exp_k,
                          ((exp_k % 2 == 1) ? FLAG_HIT : 4'h0));
        end
        $display("ordering: rsp key=%0d flag=%h", rsp_key, rsp_flag);
        exp_k++;
      end
      out_valid = (c < 8);
      out_flag  = (c % 2 == 0) ? FLAG_HIT : 4'h0;
      tick();
    end
    out_valid = 0; rsp_ready = 0;
    total++; if (exp_k !== 9) begin bad++; $display("FAIL order_count got=%0d want=8", exp_k - 1); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL order_busy got=%b want=0", busy); end
  endtask

  task automatic test_random();
    int n_rsp = 0;
    for (int c = 0; c < 600; c++) begin
      total++; if (s_ready !== (m_req.size() < 16)) begin
        bad++; $display("FAIL rnd_s_ready cyc=%0d got=%b want=%b", c, s_ready, (m_req.size() < 16));
      end
      total++; if (in_valid !== (m_req.size() > 0 && m_credits() < 8)) begin
        bad++; $display("FAIL rnd_in_valid cyc=%0d got=%b want=%b", c, in_valid, (m_req.size() > 0 && m_credits() < 8));
      end
      if (m_req.size() > 0) begin
        total++; if (in_key !== m_req[0].key || in_flag !== m_req[0].flag) begin
          bad++; $display("FAIL rnd_in_key cyc=%0d got=%h want=%h", c, in_key, m_req[0].key);
        end
      end
      total++; if (rsp_valid !== (m_rsp.size() > 0)) begin
        bad++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b want=%b", c, rsp_valid, (m_rsp.size() > 0));
      end
      if (m_rsp.size() > 0) begin
        total++; if (rsp_key !== m_rsp[0].key || rsp_flag !== m_rsp[0].flag) begin
          bad++; $display("FAIL rnd_rsp cyc=%0d got=%h/%h want=%h/%h", c, rsp_key, rsp_flag, m_rsp[0].key, m_rsp[0].flag);
        end
      end
      total++; if (busy !== (m_req.size() > 0 || m_credits() > 0) || err_spurious !== m_err) begin
        bad++; $display("FAIL rnd_busy_err cyc=%0d got=%b/%b want=%b/%b", c, busy, err_spurious,
                        (m_req.size() > 0 || m_credits() > 0), m_err);
      end
`ifdef KVS_QUEUE_STATS_EN
      total++; if (stat_req !== 32'(m_sreq) || stat_stall !== 32'(m_sstall)) begin
        bad++; $display("FAIL rnd_stats cyc=%0d got=%0d/%0d want=%0d/%0d", c, stat_req, stat_stall, m_sreq, m_sstall);
      end
`else
      total++; if (stat_req !== 32'd0 || stat_stall !== 32'd0) begin
        bad++; $display("FAIL rnd_stats cyc=%0d got=%0d/%0d want=0/0", c, stat_req, stat_stall);
      end
`endif
      if (rsp_valid && rsp_ready) n_rsp++;
      s_valid   = ($urandom_range(0, 2) != 0);
      s_key     = {$urandom, $urandom, $urandom};
      case ($urandom_range(0, 2))
        0:       s_flag = FLAG_GET;
        1:       s_flag = FLAG_SET;
        default: s_flag = FLAG_DEL;
      endcase
      in_ready  = ($urandom_range(0, 3) != 0);
      out_valid = (m_inf.size() > 0) && ($urandom_range(0, 2) == 0);
      out_flag  = $urandom_range(0, 1) ? FLAG_HIT : 4'h0;
      rsp_ready = $urandom_range(0, 1);
      tick();
    end
    flush();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rnd_busy_end got=%b want=0", busy); end
    $display("random: 600 cycles, responses taken=%0d", n_rsp);
  endtask

  task automatic test_spurious();
    out_valid = 1; out_flag = FLAG_HIT;
    tick();
    out_valid = 0;
    total++; if (err_spurious !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL spurious got=%b/%b/%b want=1/0/0", err_spurious, rsp_valid, busy);
    end
    repeat (2) tick();
    total++; if (err_spurious !== 1'b1) begin bad++; $display("FAIL spurious_sticky got=%b want=1", err_spurious); end
    $display("spurious: err=%b", err_spurious);
  endtask

  task automatic test_reset_mid();
    in_ready = 1;
    for (int i = 0; i < 4; i++) begin
      s_key = 96'(400 + i); s_flag = FLAG_GET; s_valid = 1;
      out_valid = (i == 3);
      out_flag  = FLAG_HIT;
      tick();
    end
    s_valid = 0; out_valid = 0;
    #2 rst = 1'b1;
    #1;
    total++; if (s_ready !== 0 || in_valid !== 0 || rsp_valid !== 0 || busy !== 0 || err_spurious !== 0) begin
      bad++; $display("FAIL midrst_ctl got=%b%b%b%b%b want=00000", s_ready, in_valid, rsp_valid, busy, err_spurious);
    end
    total++; if (in_key !== '0 || rsp_key !== '0 || in_flag !== '0 || rsp_flag !== '0) begin
      bad++; $display("FAIL midrst_data got=%h/%h want=0/0", in_key, rsp_key);
    end
    total++; if (stat_req !== 32'd0 || stat_stall !== 32'd0) begin
      bad++; $display("FAIL midrst_stats got=%0d/%0d want=0/0", stat_req, stat_stall);
    end
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    total++; if (s_ready !== 1 || in_valid !== 0 || busy !== 0 || rsp_valid !== 0) begin
      bad++; $display("FAIL midrst_after got=%b%b%b%b want=1000", s_ready, in_valid, busy, rsp_valid);
    end
    $display("reset_mid: queue empty after release");
  endtask

  task automatic test_stats();
    int want_req, want_stall;
`ifdef KVS_QUEUE_STATS_EN
    want_req = 5; want_stall = 3;
`else
    want_req = 0; want_stall = 0;
`endif
    for (int c = 0; c < 12; c++) begin
      s_valid  = (c < 5);
      s_key    = 96'(300 + c);
      s_flag   = FLAG_SET;
      in_ready = !(c >= 1 && c <= 3);
      tick();
    end
    s_valid = 0;
    total++; if (stat_req !== 32'(want_req)) begin bad++; $display("FAIL stats_req got=%0d want=%0d", stat_req, want_req); end
    total++; if (stat_stall !== 32'(want_stall)) begin bad++; $display("FAIL stats_stall got=%0d want=%0d", stat_stall, want_stall); end
    flush();
    $display("stats: req=%0d stall=%0d", stat_req, stat_stall);
  endtask

  initial begin
    test_reset();
    test_single();
    test_credit_limit();
    test_backpressure();
    test_ordering();
    test_random();
    test_spurious();
    test_reset_mid();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kvs_req_queue.md
Name: kvs_req_queue

Overview:
- Buffering and ordering stage between the Ethernet packet parser and db_top's KVS interface.
- Accepts key requests from the parser, issues them to db_top honouring in_ready, and records each issued key in order.
- Pairs each db_top out_valid/out_flag pulse with its originating key and returns key+flag to the packet builder through a ready/valid response port.
- Credit-limits outstanding requests so db_top's unbackpressurable response pulses can never be lost.

Parameters:
- KEY_SIZE, 96, key width in bits.
- FLAG_SIZE, 4, flag width in bits.
- REQ_LOG, 4, log2 of request FIFO depth (16 entries).
- OUT_LOG, 3, log2 of in-flight FIFO depth and response FIFO depth; MAX_OUT = 2**OUT_LOG = 8 credits.

Ports:
- clk  in  1  db_clk domain clock; single clock.
- rst  in  1  reset, asynchronous, active-high.
- s_key  in  KEY_SIZE  request key from parser.
- s_flag  in  FLAG_SIZE  request opcode flag.
- s_valid  in  1  request valid.
- s_ready  out  1  request accepted when s_valid&&s_ready.
- in_key  out  KEY_SIZE  key to db_top.
- in_flag  out  FLAG_SIZE  flag to db_top.
- in_valid  out  1  issue valid to db_top.
- in_ready  in  1  db_top accept.
- out_valid  in  1  db_top result pulse, 1 cycle per accepted request, in issue order.
- out_flag  in  FLAG_SIZE  db_top result flag.
- rsp_key  out  KEY_SIZE  key of completed request.
- rsp_flag  out  FLAG_SIZE  db_top result flag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  downstream accept.
- busy  out  1  any request queued or outstanding.
- err_spurious  out  1  sticky: out_valid arrived with no request in flight.
- stat_req  out  32  issued-request counter (optional feature).
- stat_stall  out  32  stall-cycle counter (optional feature).

Behaviour:
- Reset values: s_ready=0 while rst is asserted, 1 from the first cycle after release. in_valid=0, rsp_valid=0, busy=0, err_spurious=0, counters=0, all FIFOs empty, credits=0. in_key/rsp_key/flags=0.
- Request FIFO, 2**REQ_LOG x (KEY_SIZE+FLAG_SIZE), show-ahead:
  - s_ready = !req_full.
  - A push in cycle N makes the entry visible on in_key/in_flag with in_valid in cycle N+1 (1-cycle latency).
  - Push when full is impossible by construction, because s_ready=0.
- Issue:
  - in_valid = !req_empty && (credits != MAX_OUT).
  - in_valid/in_key/in_flag are held stable until in_ready.
  - On in_valid&&in_ready: pop the request FIFO, push the key into the in-flight FIFO, credits+1.
- Completion:
  - On out_valid with the in-flight FIFO non-empty: pop the in-flight key and push {key,out_flag} into the response FIFO.
  - rsp_valid is asserted the next cycle.
- Spurious completion: out_valid with the in-flight FIFO empty sets err_spurious, which stays set until rst. Nothing is pushed.
- Response drain: rsp_valid = !rsp_empty. On rsp_valid&&rsp_ready: pop, credits-1.
- Credit rules:
  - Credits are a 0..MAX_OUT counter covering in-flight plus buffered responses; OUT_LOG+1 bits wide.
  - Simultaneous issue and drain in one cycle leaves credits unchanged.
  - The in-flight and response FIFOs therefore can never overflow.
- Simultaneous events:
  - Request push and pop in the same cycle on a non-empty FIFO: occupancy unchanged.
  - On an empty FIFO, push then pop on the next cycle.
  - out_valid and a response pop in the same cycle: both take effect.
- Wrap-around: FIFO pointers are REQ_LOG+1 / OUT_LOG+1 bits. Full when MSBs differ and the rest are equal.
- busy = !req_empty || credits != 0.
- Reset mid-operation: all queued and in-flight state is discarded immediately. db_top shares the same rst, so no stale out_valid follows.

Optional Feature:
- KVS_QUEUE_STATS_EN defined:
  - stat_req increments on every in_valid&&in_ready.
  - stat_stall increments every cycle with in_valid&&!in_ready.
  - Both are 32-bit, saturate at 32'hFFFF_FFFF, and are cleared by rst.
- Not defined: stat_req and stat_stall are constant 0 and no counter logic is built.

Decomposition:
- Shared package kvs_pkg holds:
  - KEY_SIZE=96, VAL_SIZE=32, FLAG_SIZE=4.
  - Flag encodings FLAG_GET=4'h1, FLAG_SET=4'h2, FLAG_DEL=4'h4, FLAG_HIT=4'h8.
  - The request struct type {key,flag}.
- Sub-module kvs_sync_fifo: parameterised width and log-depth, show-ahead, full/empty flags. Instantiated three times (request, in-flight, response).

Test Plan:
- Single request: s_key=96'h1, s_flag=4'h1 accepted at cycle 0 -> in_valid at cycle 1. With in_ready=1, db out_valid/out_flag=4'h8 at cycle 5 -> rsp_valid at cycle 6 with rsp_key=96'h1, rsp_flag=4'h8. busy falls after rsp_ready.
- Credit limit: in_ready=1, out_valid never pulsed, 12 requests pushed -> exactly 8 issued, in_valid=0 with 4 queued. Draining one response releases exactly one issue.
- Backpressure: in_ready=0 with 17 pushes -> s_ready=0 after the 16th. in_key stays stable on entry 0 until in_ready=1.
- Ordering: keys 1..8 issued, out_flag pulses 8,0,8,0,... with rsp_ready toggling -> responses appear in key order 1..8 with matching flags. No loss when out_valid coincides with a rsp pop.
- Spurious and reset: out_valid with nothing in flight -> err_spurious=1 and no rsp_valid. Async rst asserted mid-burst -> all outputs at reset values in the same cycle; queue is empty after release.
- Stats (KVS_QUEUE_STATS_EN): 5 issues with 3 stalled cycles -> stat_req=5, stat_stall=3. Without the macro both read 0.
